// File: rtl/imem_loader.sv
// Boot-time byte-stream loader: assembles little-endian words into instruction memory,
// then releases cpu_reset. Optional trailing XOR checksum under LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {
        ST_HDR0 = 3'd0,
        ST_HDR1 = 3'd1,
        ST_DATA = 3'd2,
        ST_RUN  = 3'd3,
        ST_ERR  = 3'd4
`ifdef LOADER_CHECKSUM_EN
        , ST_CHECK = 3'd5
`endif
    } state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam state_t ST_TAIL = ST_CHECK;
`else
    localparam state_t ST_TAIL = ST_RUN;
`endif

    localparam logic [31:0]     MAX_WORDS_L = MAX_WORDS;
    localparam logic [ADDR_W:0] ONE_W       = (ADDR_W+1)'(1);

    state_t              state_q;
    logic [7:0]          n_lo_q;
    logic [ADDR_W:0]     n_q;
    logic [23:0]         asm_q;
    logic [1:0]          idx_q;
    logic [ADDR_W:0]     word_count_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic                cpu_reset_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          csum_q;
`endif

    logic                accept;
    logic [31:0]         n_hdr_d;
    logic [31:0]         asm_d;
    logic [ADDR_W:0]     count_d;

    always_comb begin
        in_ready = (state_q != ST_RUN) && (state_q != ST_ERR);
        accept   = in_valid && in_ready;
        n_hdr_d  = {16'd0, in_data, n_lo_q};
        asm_d    = {in_data, asm_q};
        count_d  = word_count_q + ONE_W;
    end

    // cpu_reset trails the state by one cycle so the final write lands before the first fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_HDR0;
            n_lo_q       <= 8'd0;
            n_q          <= '0;
            asm_q        <= 24'd0;
            idx_q        <= 2'd0;
            word_count_q <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'd0;
            cpu_reset_q  <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= 8'd0;
`endif
        end else begin
            mem_we_q    <= 1'b0;
            cpu_reset_q <= (state_q != ST_RUN);
            if (accept) begin
                unique case (state_q)
                    ST_HDR0: begin
                        n_lo_q  <= in_data;
                        state_q <= ST_HDR1;
                    end
                    ST_HDR1: begin
                        n_q <= n_hdr_d[ADDR_W:0];
                        if (n_hdr_d > MAX_WORDS_L) begin
                            state_q <= ST_ERR;
                        end else if (n_hdr_d == 32'd0) begin
                            state_q <= ST_TAIL;
                        end else begin
                            state_q <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        asm_q <= asm_d[31:8];
                        idx_q <= idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ in_data;
`endif
                        if (idx_q == 2'd3) begin
                            mem_we_q     <= 1'b1;
                            mem_addr_q   <= word_count_q[ADDR_W-1:0];
                            mem_wdata_q  <= asm_d;
                            word_count_q <= count_d;
                            if (count_d == n_q) begin
                                state_q <= ST_TAIL;
                            end
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    ST_CHECK: begin
                        state_q <= (in_data == csum_q) ? ST_RUN : ST_ERR;
                    end
`endif
                    default: begin
                    end
                endcase
            end
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign done       = (state_q == ST_RUN);
    assign error      = (state_q == ST_ERR);
    assign word_count = word_count_q;

endmodule
